// File: rtl/conv_sa_post_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_sa_post_ctrl: x-window / rstp / sel sequencer for one SA column's   |
// | post-processing stage, with aligned output-valid stream.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module conv_sa_post_ctrl #(
    parameter int NB = 8,
    parameter int SW = $clog2(NB),
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [CW-1:0] cfg_n_acc,
    input  logic [SW:0]   cfg_n_blk,
    input  logic [CW-1:0] cfg_n_vec,
    output logic          x_en,
    output logic          post_rstp,
    output logic [SW-1:0] post_sel,
    output logic          out_vld,
    output logic [SW-1:0] out_blk,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0]  c_IDLE  = 2'd0;
    localparam logic [1:0]  c_RUN   = 2'd1;
    localparam logic [1:0]  c_FLUSH = 2'd2;
    localparam logic [1:0]  c_FIN   = 2'd3;
    localparam logic [SW:0] c_NB    = (SW+1)'(NB);

    logic [1:0]    r_state;
    logic [CW-1:0] r_n_acc, r_n_vec, r_vec;
    logic [SW:0]   r_n_blk;
    logic [CW:0]   r_period, r_ph;
    logic          r_xl, r_xl_fin;
    logic [3:0]    r_dly, r_dly_fin;
    logic          r_sw_act, r_sw_fin;
    logic          r_pre_vld, r_pre_last;
    logic [SW-1:0] r_pre_blk;
    logic          r_x_en, r_post_rstp, r_out_vld, r_out_last, r_busy, r_done;
    logic [SW-1:0] r_post_sel, r_out_blk;

    logic          w_accept, w_prime, w_wrap, w_x_nxt, w_xl_nxt, w_xl_fin_nxt;
    logic          w_win_end, w_sw_end;
    logic [CW-1:0] w_cfg_acc, w_vec_nxt;
    logic [SW:0]   w_cfg_blk;
    logic [CW:0]   w_acc_p1, w_blk_ext, w_cfg_per, w_ph_nxt;

    always_comb begin
        w_accept     = (r_state == c_IDLE) && start;
        w_prime      = w_accept && (cfg_n_vec != '0);
        w_cfg_acc    = (cfg_n_acc == '0) ? CW'(1) : cfg_n_acc;
        w_cfg_blk    = (cfg_n_blk == '0) ? (SW+1)'(1) :
                       (cfg_n_blk > c_NB) ? c_NB : cfg_n_blk;
        w_acc_p1     = {1'b0, w_cfg_acc} + (CW+1)'(1);
        w_blk_ext    = (CW+1)'(w_cfg_blk);
        // Period keeps a one-cycle gap so no product lands in a rstp cycle.
        w_cfg_per    = (w_acc_p1 > w_blk_ext) ? w_acc_p1 : w_blk_ext;
        w_wrap       = (r_ph == r_period - (CW+1)'(1));
        w_ph_nxt     = w_wrap ? '0 : r_ph + (CW+1)'(1);
        w_vec_nxt    = w_wrap ? r_vec + CW'(1) : r_vec;
        w_win_end    = (w_vec_nxt >= r_n_vec);
        w_x_nxt      = !w_win_end && (w_ph_nxt < {1'b0, r_n_acc});
        w_xl_nxt     = w_x_nxt && (w_ph_nxt == {1'b0, r_n_acc} - (CW+1)'(1));
        w_xl_fin_nxt = w_xl_nxt && (w_vec_nxt == r_n_vec - CW'(1));
        w_sw_end     = ({1'b0, r_post_sel} == r_n_blk - (SW+1)'(1));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= c_IDLE;
            r_n_acc  <= '0;
            r_n_blk  <= '0;
            r_n_vec  <= '0;
            r_period <= '0;
            r_ph     <= '0;
            r_vec    <= '0;
            r_x_en   <= 1'b0;
            r_xl     <= 1'b0;
            r_xl_fin <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_n_acc  <= w_cfg_acc;
                        r_n_blk  <= w_cfg_blk;
                        r_n_vec  <= cfg_n_vec;
                        r_period <= w_cfg_per;
                        r_ph     <= '0;
                        r_vec    <= '0;
                        if (cfg_n_vec == '0) begin
                            r_state <= c_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state  <= c_RUN;
                            r_busy   <= 1'b1;
                            r_x_en   <= 1'b1;
                            r_xl     <= (w_cfg_acc == CW'(1));
                            r_xl_fin <= (w_cfg_acc == CW'(1)) && (cfg_n_vec == CW'(1));
                        end
                    end
                end
                c_RUN: begin
                    r_ph     <= w_ph_nxt;
                    r_vec    <= w_vec_nxt;
                    r_x_en   <= w_x_nxt;
                    r_xl     <= w_xl_nxt;
                    r_xl_fin <= w_xl_fin_nxt;
                    if (w_win_end) begin
                        r_state <= c_FLUSH;
                    end
                end
                c_FLUSH: begin
                    r_x_en   <= 1'b0;
                    r_xl     <= 1'b0;
                    r_xl_fin <= 1'b0;
                    if (r_out_last) begin
                        r_state <= c_FIN;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                c_FIN: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Latch strobe trails the last x by five cycles; sweep and valid follow it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_dly       <= '0;
            r_dly_fin   <= '0;
            r_post_rstp <= 1'b0;
            r_post_sel  <= '0;
            r_sw_act    <= 1'b0;
            r_sw_fin    <= 1'b0;
            r_pre_vld   <= 1'b0;
            r_pre_blk   <= '0;
            r_pre_last  <= 1'b0;
            r_out_vld   <= 1'b0;
            r_out_blk   <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_dly       <= {r_dly[2:0], r_xl};
            r_dly_fin   <= {r_dly_fin[2:0], r_xl_fin};
            r_post_rstp <= w_prime | r_dly[3];
            if (r_dly[3]) begin
                r_post_sel <= '0;
                r_sw_act   <= 1'b1;
                r_sw_fin   <= r_dly_fin[3];
            end else if (r_sw_act && w_sw_end) begin
                r_sw_act <= 1'b0;
            end else if (r_sw_act) begin
                r_post_sel <= r_post_sel + SW'(1);
            end
            r_pre_vld  <= r_sw_act;
            r_pre_blk  <= r_post_sel;
            r_pre_last <= r_sw_act && r_sw_fin && w_sw_end;
            r_out_vld  <= r_pre_vld;
            r_out_blk  <= r_pre_blk;
            r_out_last <= r_pre_last;
        end
    end

    assign x_en      = r_x_en;
    assign post_rstp = r_post_rstp;
    assign post_sel  = r_post_sel;
    assign out_vld   = r_out_vld;
    assign out_blk   = r_out_blk;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_conv_sa_post_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_conv_sa_post_ctrl: directed scoreboard bench with a behavioural post  |
// | stage. Revision: 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_conv_sa_post_ctrl;

    typedef struct packed {
        logic       x_en;
        logic       rstp;
        logic [2:0] sel;
        logic       vld;
        logic [2:0] blk;
        logic       last;
        logic       busy;
        logic       done;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn, start;
    logic [15:0] cfg_n_acc, cfg_n_vec;
    logic [3:0]  cfg_n_blk;
    logic        x_en, post_rstp, out_vld, out_last, busy, done;
    logic [2:0]  post_sel, out_blk;

    exp_t        exp_q[$];
    int          y_q[$];
    logic [2:0]  model_sel = '0;
    bit          chk_on = 1'b0;
    bit          y_en = 1'b0;
    bit          x_clr = 1'b0;
    int          n_app = 0;
    int          n_miss = 0;
    int          cyc = 0;

    int          x_idx = 0;
    int          xd0 = 0, xd1 = 0, xd2 = 0, pr = 0, p_acc = 0, acc = 0;
    logic [2:0]  sd1 = '0, sd2 = '0;

    conv_sa_post_ctrl #(.NB(8), .SW(3), .CW(16)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .cfg_n_acc (cfg_n_acc),
        .cfg_n_blk (cfg_n_blk),
        .cfg_n_vec (cfg_n_vec),
        .x_en      (x_en),
        .post_rstp (post_rstp),
        .post_sel  (post_sel),
        .out_vld   (out_vld),
        .out_blk   (out_blk),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Behavioural post stage: wz = 3, x numbered from 1 within a run.
    always @(posedge clk) begin
        xd0   <= x_en ? x_idx + 1 : 0;
        xd1   <= xd0;
        xd2   <= xd1;
        pr    <= xd2 * 3;
        x_idx <= x_clr ? 0 : x_idx + (x_en ? 1 : 0);
        if (post_rstp) begin
            acc   <= p_acc;
            p_acc <= 0;
        end else begin
            p_acc <= p_acc + pr;
        end
        sd1 <= post_sel;
        sd2 <= sd1;
    end

    always @(negedge clk) begin
        exp_t e, o;
        int   y;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '{x_en, post_rstp, post_sel, out_vld,
                  (out_vld ? out_blk : 3'd0), out_last, busy, done};
            n_app++;
            assert (o === e) else begin
                n_miss++;
                $error("FAIL ctl cyc %0d: got %h expected %h", cyc, o, e);
            end
        end
        if (y_en && out_vld === 1'b1) begin
            y = 100 + int'(sd2) - acc;
            n_app++;
            assert (y_q.size() > 0 && y === y_q[0]) else begin
                n_miss++;
                $error("FAIL y1 cyc %0d: got %0d expected %0d", cyc, y,
                       (y_q.size() > 0) ? y_q[0] : -1);
            end
            if (y_q.size() > 0) void'(y_q.pop_front());
        end
    end

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (chk_on && exp_q.size() == 0) begin
            e     = '0;
            e.sel = model_sel;
            exp_q.push_back(e);
        end
    endtask

    // Expected cycles 1..d relative to the start cycle, from the timing formulas.
    task automatic push_run(input int na, input int nb, input int nv,
                            input bit ychk, output int d);
        int   na1, nb1, per, r, s;
        exp_t e;
        na1 = (na == 0) ? 1 : na;
        nb1 = (nb == 0) ? 1 : ((nb > 8) ? 8 : nb);
        per = (na1 + 1 > nb1) ? na1 + 1 : nb1;
        d   = (nv == 0) ? 1 : (nv - 1) * per + na1 + 5 + nb1 + 2;
        for (int c = 1; c <= d; c++) begin
            e      = '0;
            e.busy = (c < d);
            e.done = (c == d);
            e.rstp = (nv != 0) && (c == 1);
            for (int v = 0; v < nv; v++) begin
                r = v * per + na1 + 5;
                if (c >= 1 + v * per && c <= v * per + na1) e.x_en = 1'b1;
                if (c == r) e.rstp = 1'b1;
                if (c >= r && c < r + nb1) model_sel = 3'(c - r);
                if (c >= r + 2 && c < r + 2 + nb1) begin
                    e.vld = 1'b1;
                    e.blk = 3'(c - r - 2);
                end
            end
            e.sel  = model_sel;
            e.last = e.vld && (c == d - 1);
            exp_q.push_back(e);
        end
        if (ychk) begin
            for (int v = 0; v < nv; v++) begin
                s = 0;
                for (int i = 1; i <= na1; i++) s += v * na1 + i;
                for (int k = 0; k < nb1; k++) y_q.push_back(100 + k - 3 * s);
            end
        end
    endtask

    task automatic run(input int na, input int nb, input int nv,
                       input bit pulses, input int rst_at, input bit ychk);
        int d;
        step();
        cfg_n_acc = 16'(na);
        cfg_n_blk = 4'(nb);
        cfg_n_vec = 16'(nv);
        start     = 1'b1;
        x_clr     = 1'b1;
        y_en      = ychk;
        push_run(na, nb, nv, ychk, d);
        for (int c = 1; c <= d + 1; c++) begin
            step();
            start = 1'b0;
            x_clr = 1'b0;
            rstn  = 1'b1;
            if (pulses && (c == 5 || c == d)) begin
                start     = 1'b1;
                cfg_n_acc = 16'd7;
                cfg_n_blk = 4'd1;
                cfg_n_vec = 16'd9;
            end
            if (c == rst_at) begin
                rstn = 1'b0;
                while (exp_q.size() > 1) void'(exp_q.pop_back());
                model_sel = '0;
            end
        end
    endtask

    initial begin
        rstn      = 1'b0;
        start     = 1'b0;
        cfg_n_acc = '0;
        cfg_n_blk = '0;
        cfg_n_vec = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_on = 1'b1;
        repeat (2) step();
        rstn = 1'b1;
        repeat (3) step();

        run(4, 2, 3, 1'b1, 0, 1'b0);   // base run with ignored starts / cfg changes
        repeat (3) step();
        run(2, 8, 2, 1'b0, 0, 1'b0);   // back-to-back sweeps, P set by n_blk
        repeat (2) step();
        run(4, 2, 0, 1'b0, 0, 1'b0);   // n_vec = 0
        repeat (2) step();
        run(0, 0, 2, 1'b0, 0, 1'b0);   // zero fields clamp to 1
        repeat (2) step();
        run(3, 15, 1, 1'b0, 0, 1'b0);  // n_blk above NB clamps to NB
        repeat (2) step();
        run(4, 2, 3, 1'b0, 10, 1'b0);  // abort by reset at cycle 10
        repeat (3) step();
        run(4, 2, 3, 1'b0, 0, 1'b1);   // restart, with corrected-sum check
        repeat (3) step();

        n_app++;
        assert (y_q.size() === 0) else begin
            n_miss++;
            $error("FAIL y1_drain: got %0d pending expected 0", y_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_app, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_sa_post_ctrl.md
# conv_sa_post_ctrl

Sequencer for one systolic-array column's post-processing stage. It drives the column's accumulator-clear/latch strobe (`post_rstp`) and block-select (`post_sel`), and gates the activation stream used for the weight-zero-point correction (`x_en`). It emits an output-valid stream aligned with the corrected sums `y1`/`y2`. One instance sits in the conv controller per column group, between the instruction decoder and the post stage.

## Interface
Parameters:
- NB, default `M/8: number of 8-row blocks in the column; legal NB ≥ 2.
- SW, default $clog2(NB): block-select width.
- CW, default 16: width of the length/count fields.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- rstn  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle launch; ignored while `busy`=1.
- cfg_n_acc  in  CW  reduction length per output vector (x samples); 0 is treated as 1.
- cfg_n_blk  in  SW+1  valid blocks to emit; 0 is treated as 1; values >NB are treated as NB.
- cfg_n_vec  in  CW  number of output vectors.
- x_en  out  1  the x source must present a valid sample this cycle; x must be 0 whenever x_en=0.
- post_rstp  out  1  clear-p / latch-acc strobe to the post stage.
- post_sel  out  SW  block select to the post stage.
- out_vld  out  1  y1/y2 valid this cycle.
- out_blk  out  SW  block index of the current y1/y2.
- out_last  out  1  marks the last output of the last vector.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.

## Operation
- Post-stage arithmetic pipeline:
  - x at input cycle c reaches the product register at c+4 and is added into p at the end of c+4.
  - A rstp in cycle r copies p into acc and zeroes p.
  - sel in cycle r gives y at r+2.
- Config fields are latched on the accepted start. Changes while busy have no effect.
- States:
  - IDLE: wait for start.
  - RUN: issue x windows, rstp and sel sweeps.
  - FLUSH: finish the final sweep and the out_vld pipeline.
  - FIN: pulse done for one cycle, then return to IDLE.
- Prime: in the first RUN cycle (start+1), post_rstp=1 to clear p. x_en of vector 0 also begins in this cycle.
- x windows:
  - Vector v's window lasts n_acc cycles and starts at start+1+v·P, with P = max(n_acc+1, n_blk).
  - The +1 gap is mandatory: a rstp zeroes p, so the next vector's first product must not arrive in the rstp cycle.
- Latch: for each vector, post_rstp=1 exactly 5 cycles after its last x_en cycle.
- Sweep:
  - post_sel = k in cycle r+k, for k = 0..n_blk−1, where r is that vector's latch cycle.
  - Outside sweeps post_sel holds its last value (0 after reset).
- Output:
  - out_vld=1 and out_blk=k in cycle r+2+k.
  - out_last=1 together with the final out_vld.
- Completion:
  - done=1 in the cycle after the final out_vld; busy falls in that same cycle.
  - If n_vec=0: no x_en, no rstp and no out_vld; done=1 at start+1.
- Counters: the window counter, vector counter and sweep counter are independent. The latch is produced by a 5-stage delay of a "last x" flag. Sweeps never overlap, which follows from P ≥ n_blk.

## Timing
- Reset: while rstn=0 at an edge, every output goes to 0, the FSM goes to IDLE and the delay lines clear. Reset mid-operation aborts with no done pulse. Afterwards the post stage's p is stale; the next run's prime clears it.
- Latencies:
  - start to first x_en: 1 cycle.
  - last x of a vector to post_rstp: 5 cycles.
  - post_rstp to first out_vld: 2 cycles.
  - final out_vld to done: 1 cycle.
- start asserted in the same cycle as done: ignored. It is accepted from the next cycle.
- All outputs are registered.

## Test plan
- NB=8, n_acc=4, n_blk=2, n_vec=3, start at cycle 0 ->
  - x_en in cycles 1–4, 6–9, 11–14.
  - post_rstp at 1, 9, 14, 19.
  - post_sel 0,1 at 9–10, 14–15, 19–20.
  - out_vld at 11–12, 16–17, 21–22; out_last at 22.
  - done at 23.
- n_acc=2, n_blk=8, n_vec=2, start at 0 ->
  - x_en 1–2 and 9–10.
  - post_rstp at 1, 7, 15.
  - post_sel 0..7 at 7–14 and 15–22.
  - out_vld 9–16 and 17–24; done at 25.
- Functional check with a connected post stage, wz=3, x=1..4 for vector 0 -> vector 0's acc = 30, and y1 = sum1 − 30 for both out_blk values.
- n_vec=0 -> done at 1 with no other strobe. Then start with n_acc=0, n_blk=0 -> behaves as n_acc=1, n_blk=1.
- rstn=0 for one cycle at cycle 10 of the first scenario -> all outputs 0 from cycle 11 and no done. A restart then reproduces the first scenario's timing exactly.
- start pulses at cycles 5 and 23 during the first scenario -> both ignored, and the run's outputs are unchanged.
